result_buf_wr: RTL and testbench

RESULT_BUF_WR -- requirements
Module: result_buf_wr

---
 rtl/mnist_pkg.sv | 27 ++
 rtl/result_buf_wr_if.sv | 26 ++
 rtl/argmax_acc.sv | 51 +++++
 rtl/result_buf_wr.sv | 71 +++++++
 tb/tb_result_buf_wr.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mnist_pkg.sv
// mnist_pkg: shared constants, result word layout and FSM encoding for the result buffer writer
package mnist_pkg;
    localparam int NUM_CLASS = 10;
    localparam int LOGIT_W   = 16;
    localparam int CLS_W     = 4;
    localparam int ERR_BIT   = 31;
    localparam int MAX_LSB   = 8;
    localparam int MAX_W     = 16;
    localparam int IDX_LSB   = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] pack_result(input logic err, input logic [MAX_W-1:0] max_v,
                                                input logic [CLS_W-1:0] idx);
        logic [31:0] w;
        w = '0;
        w[ERR_BIT] = err;
        w[MAX_LSB +: MAX_W] = max_v;
        w[IDX_LSB +: CLS_W] = idx;
        return w;
    endfunction
endpackage

// File: rtl/result_buf_wr_if.sv
// result_buf_wr_if: logit stream in, result-buffer write port and status out
interface result_buf_wr_if #(
    parameter int LOGIT_W = mnist_pkg::LOGIT_W,
    parameter int ADDR_W  = 4
);
    logic                      start_i;
    logic                      logit_valid_i;
    logic signed [LOGIT_W-1:0] logit_i;
    logic                      logit_last_i;
    logic                      logit_ready_o;
    logic                      buf_we_o;
    logic [ADDR_W-1:0]         buf_addr_o;
    logic [31:0]               buf_wdata_o;
    logic                      buf_wr_done_o;
    logic                      busy_o;

    modport master (
        output start_i, logit_valid_i, logit_i, logit_last_i,
        input  logit_ready_o, buf_we_o, buf_addr_o, buf_wdata_o, buf_wr_done_o, busy_o
    );

    modport slave (
        input  start_i, logit_valid_i, logit_i, logit_last_i,
        output logit_ready_o, buf_we_o, buf_addr_o, buf_wdata_o, buf_wr_done_o, busy_o
    );
endinterface

// File: rtl/argmax_acc.sv
// argmax_acc: running signed argmax over the logits of one image, with framing error flag
module argmax_acc
    import mnist_pkg::*;
#(
    parameter int LOGIT_W   = mnist_pkg::LOGIT_W,
    parameter int NUM_CLASS = mnist_pkg::NUM_CLASS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      en_i,
    input  logic                      last_i,
    input  logic signed [LOGIT_W-1:0] logit_i,
    output logic                      end_o,
    output logic signed [LOGIT_W-1:0] cur_max_o,
    output logic [CLS_W-1:0]          cur_idx_o,
    output logic                      err_o
);
    logic [CLS_W-1:0] beat_cnt;
    logic             full;
    logic             take;

    // An image ends on last or once the final class slot is filled; first beat always seeds the max
    always_comb begin
        full  = beat_cnt == CLS_W'(NUM_CLASS - 1);
        end_o = en_i && (last_i || full);
        take  = beat_cnt == '0 || logit_i > cur_max_o;
    end

    // Count beats, keep strict-greater max so ties hold the lower index, flag malformed images
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt  <= '0;
            cur_max_o <= '0;
            cur_idx_o <= '0;
            err_o     <= 1'b0;
        end else if (clr_i) begin
            beat_cnt  <= '0;
            cur_max_o <= '0;
            cur_idx_o <= '0;
            err_o     <= 1'b0;
        end else if (en_i) begin
            beat_cnt <= beat_cnt + CLS_W'(1);
            if (take) begin
                cur_max_o <= logit_i;
                cur_idx_o <= beat_cnt;
            end
            if (end_o) err_o <= !(last_i && full);
        end
    end
endmodule

// File: rtl/result_buf_wr.sv
// result_buf_wr: writes one argmax result word per image into the result buffer
module result_buf_wr
    import mnist_pkg::*;
#(
    parameter int NUM_IMG   = 16,
    parameter int NUM_CLASS = mnist_pkg::NUM_CLASS,
    parameter int LOGIT_W   = mnist_pkg::LOGIT_W,
    parameter int ADDR_W    = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    result_buf_wr_if.slave bus
);
    state_t                    state, state_n;
    logic [ADDR_W-1:0]         img_cnt;
    logic                      go;
    logic                      frame_end;
    logic                      done_q;
    logic                      acc_end;
    logic                      acc_err;
    logic signed [LOGIT_W-1:0] cur_max;
    logic [CLS_W-1:0]          cur_idx;
    logic [MAX_W-1:0]          max_ext;

    argmax_acc #(.LOGIT_W(LOGIT_W), .NUM_CLASS(NUM_CLASS)) u_acc (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (go || state == S_WR),
        .en_i     (bus.logit_valid_i && bus.logit_ready_o),
        .last_i   (bus.logit_last_i),
        .logit_i  (bus.logit_i),
        .end_o    (acc_end),
        .cur_max_o(cur_max),
        .cur_idx_o(cur_idx),
        .err_o    (acc_err)
    );

    // Next state and port strobes; start only counts from IDLE or DONE
    always_comb begin
        go        = bus.start_i && (state == S_IDLE || state == S_DONE);
        frame_end = img_cnt == ADDR_W'(NUM_IMG - 1);
        state_n   = state;
        case (state)
            S_IDLE, S_DONE: state_n = go ? S_RUN : state;
            S_RUN:          state_n = acc_end ? S_WR : S_RUN;
            S_WR:           state_n = frame_end ? S_DONE : S_RUN;
            default:        state_n = S_IDLE;
        endcase
        max_ext           = MAX_W'(cur_max);
        bus.logit_ready_o = state == S_RUN;
        bus.buf_we_o      = state == S_WR;
        bus.busy_o        = state == S_RUN || state == S_WR;
        bus.buf_addr_o    = img_cnt;
        bus.buf_wdata_o   = pack_result(acc_err, max_ext, cur_idx);
        bus.buf_wr_done_o = done_q;
    end

    // State register, image address (held at the last slot once the frame is full) and done pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            img_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= state == S_WR && frame_end;
            if (go) img_cnt <= '0;
            else if (state == S_WR && !frame_end) img_cnt <= img_cnt + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_result_buf_wr.sv
// tb_result_buf_wr: directed and randomized checks of result_buf_wr against a per-image argmax model
module tb_result_buf_wr;
    localparam int NUM_IMG = 2;
    localparam int NC      = 10;
    localparam int LW      = 16;
    localparam int AW      = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_ready_bad = 0;
    int          last_t = 0;
    int          w_addr[$];
    int          w_cyc[$];
    int          d_cyc[$];
    logic [31:0] w_data[$];

    result_buf_wr_if #(.LOGIT_W(LW), .ADDR_W(AW)) b ();

    result_buf_wr #(.NUM_IMG(NUM_IMG), .NUM_CLASS(NC), .LOGIT_W(LW), .ADDR_W(AW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (b)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time writes and done pulses relative to the last beat
    always @(posedge clk) cyc <= cyc + 1;

    // Record every write and done pulse away from the active edge
    always @(negedge clk) begin
        if (b.buf_we_o) begin
            w_addr.push_back(int'(b.buf_addr_o));
            w_data.push_back(b.buf_wdata_o);
            w_cyc.push_back(cyc);
            if (b.logit_ready_o) wr_ready_bad++;
        end
        if (b.buf_wr_done_o) d_cyc.push_back(cyc);
    end

    function automatic logic [31:0] word(input bit err, input int mx, input int idx);
        logic [15:0] m;
        logic [3:0]  c;
        m = 16'(mx);
        c = 4'(idx);
        return {err, 7'b0, m, 4'b0, c};
    endfunction

    task automatic clear_log;
        w_addr.delete();
        w_data.delete();
        w_cyc.delete();
        d_cyc.delete();
        wr_ready_bad = 0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        b.start_i = 1'b0;
        b.logit_valid_i = 1'b0;
        b.logit_i = '0;
        b.logit_last_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic start;
        @(negedge clk);
        b.start_i = 1'b1;
        @(negedge clk);
        b.start_i = 1'b0;
    endtask

    task automatic beat(input int v, input bit l);
        int n;
        n = 0;
        @(negedge clk);
        b.logit_valid_i = 1'b1;
        b.logit_i = 16'(v);
        b.logit_last_i = l;
        while (!b.logit_ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 40) begin
            n_bad++;
            $display("FAIL beat_accept: ready stayed %b for 40 cycles, required 1", b.logit_ready_o);
        end
        last_t = cyc;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            b.logit_valid_i = 1'b0;
            b.logit_last_i = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [31:0] got[6];
        string       nm[6];
        nm = '{"ready", "we", "done", "busy", "addr", "wdata"};
        rst = 1'b1;
        @(negedge clk);
        got = '{32'(b.logit_ready_o), 32'(b.buf_we_o), 32'(b.buf_wr_done_o), 32'(b.busy_o),
                32'(b.buf_addr_o), b.buf_wdata_o};
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got[i] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_%s: got %0h, required 0", nm[i], got[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 5; i++) beat_idle(i);
        gap(3);
        n_cmp++;
        if (w_data.size() != 0) begin
            n_bad++;
            $display("FAIL idle_no_write: got %0d writes, required 0", w_data.size());
        end
    endtask

    task automatic beat_idle(input int v);
        @(negedge clk);
        b.logit_valid_i = 1'b1;
        b.logit_i = 16'(v);
        b.logit_last_i = 1'b1;
        n_cmp++;
        if (b.logit_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ready: got %b, required 0", b.logit_ready_o);
        end
    endtask

    task automatic test_single;
        int v[NC];
        v = '{3, -5, 7, 7, 2, 0, 1, -1, 6, 4};
        do_reset();
        start();
        for (int i = 0; i < NC; i++) begin
            beat(v[i], i == NC - 1);
            b.start_i = (i == 3);
        end
        gap(4);
        n_cmp++;
        if (w_data.size() != 1) begin
            n_bad++;
            $display("FAIL single_count: got %0d writes, required 1", w_data.size());
        end
        if (w_data.size() >= 1) begin
            n_cmp += 3;
            if (w_addr[0] != 0) begin
                n_bad++;
                $display("FAIL single_addr: got %0d, required 0", w_addr[0]);
            end
            if (w_data[0] !== word(1'b0, 7, 2)) begin
                n_bad++;
                $display("FAIL single_data: got %h, required %h", w_data[0], word(1'b0, 7, 2));
            end
            if (w_cyc[0] != last_t + 1) begin
                n_bad++;
                $display("FAIL single_latency: got cycle %0d, required %0d", w_cyc[0], last_t + 1);
            end
        end
        n_cmp += 2;
        if (d_cyc.size() != 0) begin
            n_bad++;
            $display("FAIL single_done: got %0d pulses, required 0", d_cyc.size());
        end
        if (b.busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL single_busy: got %b, required 1", b.busy_o);
        end
    endtask

    task automatic test_frame;
        do_reset();
        start();
        for (int i = 0; i < NC; i++) begin
            beat(i * 10, i == NC - 1);
            gap($urandom_range(0, 2));
        end
        for (int i = 0; i < NC; i++) begin
            beat(100 - i, i == NC - 1);
            gap($urandom_range(0, 2));
        end
        gap(5);
        n_cmp++;
        if (w_data.size() != 2) begin
            n_bad++;
            $display("FAIL frame_count: got %0d writes, required 2", w_data.size());
        end
        if (w_data.size() == 2) begin
            n_cmp += 4;
            if (w_addr[0] != 0 || w_addr[1] != 1) begin
                n_bad++;
                $display("FAIL frame_addr: got %0d,%0d, required 0,1", w_addr[0], w_addr[1]);
            end
            if (w_data[0] !== word(1'b0, 90, 9)) begin
                n_bad++;
                $display("FAIL frame_data0: got %h, required %h", w_data[0], word(1'b0, 90, 9));
            end
            if (w_data[1] !== word(1'b0, 100, 0)) begin
                n_bad++;
                $display("FAIL frame_data1: got %h, required %h", w_data[1], word(1'b0, 100, 0));
            end
            if (w_cyc[1] != last_t + 1) begin
                n_bad++;
                $display("FAIL frame_latency: got cycle %0d, required %0d", w_cyc[1], last_t + 1);
            end
        end
        n_cmp++;
        if (d_cyc.size() != 1) begin
            n_bad++;
            $display("FAIL frame_done_count: got %0d pulses, required 1", d_cyc.size());
        end
        if (d_cyc.size() == 1) begin
            n_cmp++;
            if (d_cyc[0] != last_t + 2) begin
                n_bad++;
                $display("FAIL frame_done_time: got cycle %0d, required %0d", d_cyc[0], last_t + 2);
            end
        end
        n_cmp++;
        if (b.busy_o !== 1'b0 || b.logit_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_idle_after: got busy %b ready %b, required 0 0", b.busy_o, b.logit_ready_o);
        end
    endtask

    task automatic test_min;
        do_reset();
        start();
        for (int i = 0; i < NC; i++) beat(-32768, i == NC - 1);
        gap(3);
        n_cmp++;
        if (w_data.size() != 1) begin
            n_bad++;
            $display("FAIL min_count: got %0d writes, required 1", w_data.size());
        end
        if (w_data.size() == 1) begin
            n_cmp++;
            if (w_data[0] !== word(1'b0, -32768, 0)) begin
                n_bad++;
                $display("FAIL min_data: got %h, required %h", w_data[0], word(1'b0, -32768, 0));
            end
        end
    endtask

    task automatic test_short;
        int s[6];
        int f[NC];
        s = '{1, 9, 2, 9, 3, 0};
        f = '{5, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        do_reset();
        start();
        for (int i = 0; i < 6; i++) beat(s[i], i == 5);
        for (int i = 0; i < NC; i++) beat(f[i], i == NC - 1);
        gap(4);
        n_cmp++;
        if (w_data.size() != 2) begin
            n_bad++;
            $display("FAIL short_count: got %0d writes, required 2", w_data.size());
        end
        if (w_data.size() == 2) begin
            n_cmp += 3;
            if (w_data[0] !== word(1'b1, 9, 1)) begin
                n_bad++;
                $display("FAIL short_data0: got %h, required %h", w_data[0], word(1'b1, 9, 1));
            end
            if (w_data[1] !== word(1'b0, 5, 0)) begin
                n_bad++;
                $display("FAIL short_data1: got %h, required %h", w_data[1], word(1'b0, 5, 0));
            end
            if (w_addr[1] != 1) begin
                n_bad++;
                $display("FAIL short_addr1: got %0d, required 1", w_addr[1]);
            end
        end
    endtask

    task automatic test_overrun;
        int g[NC];
        g = '{0, 0, 0, 8, 0, 0, 8, 0, 0, 0};
        do_reset();
        start();
        for (int i = 0; i < NC; i++) beat(i, 1'b0);
        for (int i = 0; i < NC; i++) beat(g[i], i == NC - 1);
        gap(4);
        n_cmp++;
        if (w_data.size() != 2) begin
            n_bad++;
            $display("FAIL overrun_count: got %0d writes, required 2", w_data.size());
        end
        if (w_data.size() == 2) begin
            n_cmp += 2;
            if (w_data[0] !== word(1'b1, 9, 9)) begin
                n_bad++;
                $display("FAIL overrun_data0: got %h, required %h", w_data[0], word(1'b1, 9, 9));
            end
            if (w_data[1] !== word(1'b0, 8, 3)) begin
                n_bad++;
                $display("FAIL overrun_data1: got %h, required %h", w_data[1], word(1'b0, 8, 3));
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] got[5];
        string       nm[5];
        nm = '{"ready", "busy", "we", "done", "wdata"};
        do_reset();
        start();
        for (int i = 0; i < 4; i++) beat(20 + i, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        got = '{32'(b.logit_ready_o), 32'(b.busy_o), 32'(b.buf_we_o), 32'(b.buf_wr_done_o), b.buf_wdata_o};
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (got[i] !== 32'h0) begin
                n_bad++;
                $display("FAIL midrst_%s: got %0h, required 0", nm[i], got[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            b.logit_valid_i = 1'b1;
            b.logit_last_i = (i % 3 == 2);
        end
        gap(3);
        n_cmp += 2;
        if (w_data.size() != 0) begin
            n_bad++;
            $display("FAIL midrst_no_write: got %0d writes, required 0", w_data.size());
        end
        if (d_cyc.size() != 0) begin
            n_bad++;
            $display("FAIL midrst_no_done: got %0d pulses, required 0", d_cyc.size());
        end
        start();
        for (int i = 0; i < NC; i++) beat(i == 6 ? 50 : -3, i == NC - 1);
        gap(3);
        n_cmp++;
        if (w_data.size() != 1 || w_data[0] !== word(1'b0, 50, 6) || w_addr[0] != 0) begin
            n_bad++;
            $display("FAIL midrst_restart: got %0d writes first %h, required 1 write %h at addr 0",
                     w_data.size(), w_data.size() > 0 ? w_data[0] : 32'h0, word(1'b0, 50, 6));
        end
    endtask

    task automatic test_random;
        int          e_addr[$];
        logic [31:0] e_data[$];
        int          vals[NC];
        int          kind, len, best, lt;
        bit          has_last;
        do_reset();
        for (int f = 0; f < 8; f++) begin
            clear_log();
            e_addr.delete();
            e_data.delete();
            start();
            for (int img = 0; img < NUM_IMG; img++) begin
                kind = int'($urandom_range(0, 3));
                len = (kind == 2) ? int'($urandom_range(1, NC - 1)) : NC;
                has_last = (kind != 3);
                for (int i = 0; i < len; i++)
                    vals[i] = $urandom_range(0, 1) ? int'($urandom_range(0, 65535)) - 32768
                                                   : int'($urandom_range(0, 4)) - 2;
                best = 0;
                for (int i = 1; i < len; i++) if (vals[i] > vals[best]) best = i;
                e_addr.push_back(img);
                e_data.push_back(word(!(has_last && len == NC), vals[best], best));
                for (int i = 0; i < len; i++) begin
                    beat(vals[i], has_last && i == len - 1);
                    gap($urandom_range(0, 2));
                end
            end
            lt = last_t;
            gap(4);
            n_cmp++;
            if (w_data.size() != e_data.size()) begin
                n_bad++;
                $display("FAIL rand_count f%0d: got %0d writes, required %0d", f, w_data.size(), e_data.size());
            end
            for (int i = 0; i < e_data.size() && i < w_data.size(); i++) begin
                n_cmp++;
                if (w_data[i] !== e_data[i] || w_addr[i] != e_addr[i]) begin
                    n_bad++;
                    $display("FAIL rand_write f%0d i%0d: got %h@%0d, required %h@%0d",
                             f, i, w_data[i], w_addr[i], e_data[i], e_addr[i]);
                end
            end
            n_cmp += 2;
            if (d_cyc.size() != 1 || d_cyc[0] != lt + 2) begin
                n_bad++;
                $display("FAIL rand_done f%0d: got %0d pulses first at %0d, required 1 at %0d",
                         f, d_cyc.size(), d_cyc.size() > 0 ? d_cyc[0] : -1, lt + 2);
            end
            if (wr_ready_bad != 0) begin
                n_bad++;
                $display("FAIL rand_ready_in_wr f%0d: got %0d write cycles with ready high, required 0", f, wr_ready_bad);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_frame();
        test_min();
        test_short();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
